// File: rtl/exe_stage_md_if.sv
// ds->es handshake and instruction bundle.
// master = decode side, slave = execute side; es_allowin flows back.
interface exe_stage_md_if #(
  parameter int XLEN = 32
);
  logic            ds_to_es_valid;
  logic            es_allowin;
  logic [11:0]     ds_alu_op;
  logic [XLEN-1:0] ds_src1;
  logic [XLEN-1:0] ds_src2;
  logic [XLEN-1:0] ds_rt_value;
  logic [3:0]      ds_md_op;
  logic [3:0]      ds_hilo_op;
  logic [2:0]      ds_mem_op;
  logic [1:0]      ds_mem_size;
  logic            ds_gr_we;
  logic [4:0]      ds_dest;
  logic [XLEN-1:0] ds_pc;

  modport master (
    output ds_to_es_valid, ds_alu_op,
    output ds_src1, ds_src2, ds_rt_value,
    output ds_md_op, ds_hilo_op,
    output ds_mem_op, ds_mem_size,
    output ds_gr_we, ds_dest, ds_pc,
    input  es_allowin
  );

  modport slave (
    input  ds_to_es_valid, ds_alu_op,
    input  ds_src1, ds_src2, ds_rt_value,
    input  ds_md_op, ds_hilo_op,
    input  ds_mem_op, ds_mem_size,
    input  ds_gr_we, ds_dest, ds_pc,
    output es_allowin
  );
endinterface

// File: rtl/exe_stage_md.sv
// MIPS execute stage: ALU, HI/LO mult, iterative divider, store strobes.
// Ports: clk/reset, ds (ds->es bundle), ms_allowin, es->ms bundle, data SRAM, hazard/forward.
module exe_stage_md #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  exe_stage_md_if.slave     ds,
  input  logic              ms_allowin,
  output logic              es_to_ms_valid,
  output logic [XLEN-1:0]   es_to_ms_result,
  output logic [XLEN-1:0]   es_to_ms_pc,
  output logic [4:0]        es_to_ms_dest,
  output logic              es_to_ms_gr_we,
  output logic              es_to_ms_load,
  output logic [1:0]        es_to_ms_size,
  output logic [1:0]        es_to_ms_addr_lo,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [XLEN-1:0]   data_sram_wdata,
  output logic [4:0]        es_wreg_addr,
  output logic              es_load_op,
  output logic              es_fwd_valid,
  output logic [XLEN-1:0]   es_fwd_data
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_st_e;

  logic            es_valid_q;
  logic [11:0]     alu_op_q;
  logic [XLEN-1:0] src1_q, src2_q, rt_q, pc_q;
  logic [3:0]      md_op_q, hilo_op_q;
  logic [2:0]      mem_op_q;
  logic [1:0]      size_q;
  logic            gr_we_q;
  logic [4:0]      dest_q;
  logic [XLEN-1:0] hi_q, lo_q;

  div_st_e         st_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] dq_q, dr_q, dd_q;

  logic is_div, is_sdiv, is_mul;
  logic ready_go, allowin, leave;
  assign is_div  = md_op_q[3] | md_op_q[2];
  assign is_sdiv = md_op_q[3];
  assign is_mul  = md_op_q[1] | md_op_q[0];

  assign ready_go      = !is_div || (st_q == DONE);
  assign allowin       = !es_valid_q || (ready_go && ms_allowin);
  assign leave         = es_valid_q && ready_go && ms_allowin;
  assign ds.es_allowin = allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      alu_op_q   <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      rt_q       <= '0;
      pc_q       <= '0;
      md_op_q    <= '0;
      hilo_op_q  <= '0;
      mem_op_q   <= '0;
      size_q     <= '0;
      gr_we_q    <= 1'b0;
      dest_q     <= '0;
    end else begin
      if (allowin) es_valid_q <= ds.ds_to_es_valid;
      if (allowin && ds.ds_to_es_valid) begin
        alu_op_q  <= ds.ds_alu_op;
        src1_q    <= ds.ds_src1;
        src2_q    <= ds.ds_src2;
        rt_q      <= ds.ds_rt_value;
        pc_q      <= ds.ds_pc;
        md_op_q   <= ds.ds_md_op;
        hilo_op_q <= ds.ds_hilo_op;
        mem_op_q  <= ds.ds_mem_op;
        size_q    <= ds.ds_mem_size;
        gr_we_q   <= ds.ds_gr_we;
        dest_q    <= ds.ds_dest;
      end
    end
  end

  // Divider works on magnitudes; signs are restored from the latched operands.
  logic            s1_neg, s2_neg, q_neg, div_zero;
  logic [XLEN-1:0] mag1, mag2, div_lo, div_hi, sub_d;
  logic [XLEN:0]   shl;
  logic            ge;
  assign s1_neg   = is_sdiv & src1_q[XLEN-1];
  assign s2_neg   = is_sdiv & src2_q[XLEN-1];
  assign q_neg    = s1_neg ^ s2_neg;
  assign div_zero = (src2_q == '0);
  assign mag1     = s1_neg ? -src1_q : src1_q;
  assign mag2     = s2_neg ? -src2_q : src2_q;
  assign shl      = {dr_q, dq_q[XLEN-1]};
  assign ge       = shl >= {1'b0, dd_q};
  assign sub_d    = shl[XLEN-1:0] - dd_q;
  assign div_lo   = div_zero ? '1 : (q_neg ? -dq_q : dq_q);
  assign div_hi   = div_zero ? src1_q : (s1_neg ? -dr_q : dr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      dq_q  <= '0;
      dr_q  <= '0;
      dd_q  <= '0;
    end else begin
      unique case (st_q)
        IDLE: if (es_valid_q && is_div) begin
          st_q  <= RUN;
          cnt_q <= '0;
          dq_q  <= mag1;
          dd_q  <= mag2;
          dr_q  <= '0;
        end
        RUN: begin
          dq_q  <= {dq_q[XLEN-2:0], ge};
          dr_q  <= ge ? sub_d : shl[XLEN-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) st_q <= DONE;
        end
        DONE: if (leave) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end

  logic [2*XLEN-1:0] op1x, op2x, prod;
  assign op1x = {{XLEN{md_op_q[1] & src1_q[XLEN-1]}}, src1_q};
  assign op2x = {{XLEN{md_op_q[1] & src2_q[XLEN-1]}}, src2_q};
  assign prod = op1x * op2x;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (leave) begin
      unique case (1'b1)
        is_div: begin
          hi_q <= div_hi;
          lo_q <= div_lo;
        end
        is_mul: begin
          hi_q <= prod[2*XLEN-1:XLEN];
          lo_q <= prod[XLEN-1:0];
        end
        hilo_op_q[1]: hi_q <= src1_q;
        hilo_op_q[0]: lo_q <= src1_q;
        default: ;
      endcase
    end
  end

  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   sa;
  assign sa = src1_q[SW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      alu_op_q[0]:  alu_res = src1_q + src2_q;
      alu_op_q[1]:  alu_res = src1_q - src2_q;
      alu_op_q[2]:  alu_res = {{(XLEN-1){1'b0}},
                     $signed(src1_q) < $signed(src2_q)};
      alu_op_q[3]:  alu_res = {{(XLEN-1){1'b0}}, src1_q < src2_q};
      alu_op_q[4]:  alu_res = src1_q & src2_q;
      alu_op_q[5]:  alu_res = ~(src1_q | src2_q);
      alu_op_q[6]:  alu_res = src1_q | src2_q;
      alu_op_q[7]:  alu_res = src1_q ^ src2_q;
      alu_op_q[8]:  alu_res = src2_q << sa;
      alu_op_q[9]:  alu_res = src2_q >> sa;
      alu_op_q[10]: alu_res = $signed(src2_q) >>> sa;
      alu_op_q[11]: alu_res = src2_q << 16;
      default: ;
    endcase
  end

  logic [1:0] addr_lo;
  assign addr_lo = alu_res[1:0];

  // Misaligned half/word stores are silently dropped.
  always_comb begin
    data_sram_wen   = 4'h0;
    data_sram_wdata = rt_q;
    if (es_valid_q && mem_op_q[1]) begin
      unique case (size_q)
        2'd0: begin
          data_sram_wen   = 4'b0001 << addr_lo;
          data_sram_wdata = {(XLEN/8){rt_q[7:0]}};
        end
        2'd1: begin
          if (!addr_lo[0]) data_sram_wen = 4'b0011 << addr_lo;
          data_sram_wdata = {(XLEN/16){rt_q[15:0]}};
        end
        2'd2: if (addr_lo == 2'b00) data_sram_wen = 4'hf;
        default: ;
      endcase
    end
  end

  logic [XLEN-1:0] result;
  assign result = hilo_op_q[3] ? hi_q :
                  hilo_op_q[2] ? lo_q : alu_res;

  assign es_to_ms_valid   = es_valid_q && ready_go;
  assign es_to_ms_result  = result;
  assign es_to_ms_pc      = pc_q;
  assign es_to_ms_dest    = dest_q;
  assign es_to_ms_gr_we   = gr_we_q;
  assign es_to_ms_load    = mem_op_q[2];
  assign es_to_ms_size    = size_q;
  assign es_to_ms_addr_lo = addr_lo;
  assign data_sram_en     = 1'b1;
  assign data_sram_addr   = alu_res[ADDR_W-1:0];
  assign es_wreg_addr     = dest_q & {5{es_valid_q && gr_we_q}};
  assign es_load_op       = es_valid_q && mem_op_q[2];
  assign es_fwd_valid     = es_valid_q && gr_we_q &&
                            !mem_op_q[2] && ready_go;
  assign es_fwd_data      = result;

  logic unused_bits;
  assign unused_bits = mem_op_q[0];
endmodule

// File: tb/tb_exe_stage_md.sv
// Bench for exe_stage_md: directed and random instructions
// checked against an arithmetic HI/LO/ALU/store model.
module tb_exe_stage_md;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ms_allowin = 1'b1;
  always #5 clk = ~clk;

  exe_stage_md_if #(.XLEN(32)) dsif ();

  logic        es_to_ms_valid, es_to_ms_gr_we, es_to_ms_load;
  logic [31:0] es_to_ms_result, es_to_ms_pc;
  logic [4:0]  es_to_ms_dest, es_wreg_addr;
  logic [1:0]  es_to_ms_size, es_to_ms_addr_lo;
  logic        data_sram_en, es_load_op, es_fwd_valid;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, es_fwd_data;

  exe_stage_md #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .ds(dsif),
    .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid),
    .es_to_ms_result(es_to_ms_result),
    .es_to_ms_pc(es_to_ms_pc),
    .es_to_ms_dest(es_to_ms_dest),
    .es_to_ms_gr_we(es_to_ms_gr_we),
    .es_to_ms_load(es_to_ms_load),
    .es_to_ms_size(es_to_ms_size),
    .es_to_ms_addr_lo(es_to_ms_addr_lo),
    .data_sram_en(data_sram_en),
    .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .es_wreg_addr(es_wreg_addr),
    .es_load_op(es_load_op),
    .es_fwd_valid(es_fwd_valid),
    .es_fwd_data(es_fwd_data)
  );

  typedef struct packed {
    logic [11:0] alu;
    logic [31:0] s1, s2, rt;
    logic [3:0]  md, hl;
    logic [2:0]  mem;
    logic [1:0]  size;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] pc;
  } ins_t;

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [3:0] MD_DIV = 4'b1000, MD_DIVU = 4'b0100;
  localparam logic [3:0] MD_MUL = 4'b0010, MD_MULU = 4'b0001;
  localparam logic [3:0] HL_MFHI = 4'b1000, HL_MFLO = 4'b0100;
  localparam logic [3:0] HL_MTHI = 4'b0010, HL_MTLO = 4'b0001;
  localparam logic [2:0] MEM_LD = 3'b100, MEM_ST = 3'b010;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mhi = 0, mlo = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [11:0] alu,
      input logic [31:0] s1, s2, rt, input logic [3:0] md, hl,
      input logic [2:0] mem, input logic [1:0] size, input logic we);
    ins_t t;
    t.alu = alu; t.s1 = s1; t.s2 = s2; t.rt = rt;
    t.md = md; t.hl = hl; t.mem = mem; t.size = size;
    t.we = we; t.dest = 5'($urandom_range(1, 31));
    t.pc = $urandom & 32'hffff_fffc;
    return t;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [11:0] op,
                                          input logic [31:0] a, b);
    int sh = int'(a[4:0]);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return ($signed(a) < $signed(b)) ? 1 : 0;
      12'h008: return (a < b) ? 1 : 0;
      12'h010: return a & b;
      12'h020: return ~(a | b);
      12'h040: return a | b;
      12'h080: return a ^ b;
      12'h100: return b << sh;
      12'h200: return b >> sh;
      12'h400: return $signed(b) >>> sh;
      12'h800: return {b[15:0], 16'h0};
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] wen_ref(input ins_t t);
    int a = int'(alu_ref(t.alu, t.s1, t.s2) % 4);
    if (t.mem != MEM_ST) return 0;
    if (t.size == 0) return 4'(1 << a);
    if (t.size == 1) return (a % 2 == 0) ? 4'(3 << a) : 4'h0;
    if (t.size == 2) return (a == 0) ? 4'hf : 4'h0;
    return 0;
  endfunction

  task automatic model_commit(input ins_t t);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(t.s1));
    sb = longint'($signed(t.s2));
    if (t.md == MD_DIV || t.md == MD_DIVU) begin
      if (t.s2 == 0) begin
        mlo = 32'hffff_ffff; mhi = t.s1;
      end else if (t.md == MD_DIVU) begin
        mlo = t.s1 / t.s2; mhi = t.s1 % t.s2;
      end else begin
        p = 64'(sa / sb); mlo = p[31:0];
        p = 64'(sa % sb); mhi = p[31:0];
      end
    end else if (t.md == MD_MUL) begin
      p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0];
    end else if (t.md == MD_MULU) begin
      p = {32'h0, t.s1} * {32'h0, t.s2};
      mhi = p[63:32]; mlo = p[31:0];
    end else if (t.hl == HL_MTHI) mhi = t.s1;
    else if (t.hl == HL_MTLO) mlo = t.s1;
  endtask

  task automatic run(input ins_t t, input int hold,
                     output logic [31:0] res, output logic [3:0] wen);
    int cyc, ecyc;
    logic [31:0] er, ea;
    logic [3:0] ew;
    logic fv;
    ea = alu_ref(t.alu, t.s1, t.s2);
    er = (t.hl == HL_MFHI) ? mhi : (t.hl == HL_MFLO) ? mlo : ea;
    ecyc = (t.md == MD_DIV || t.md == MD_DIVU) ? 33 : 0;
    ew = wen_ref(t);
    fv = t.we && (t.mem != MEM_LD);
    @(negedge clk);
    chk("allowin_idle", es_allowin_w(), 1);
    dsif.ds_to_es_valid = 1'b1;
    dsif.ds_alu_op = t.alu; dsif.ds_src1 = t.s1;
    dsif.ds_src2 = t.s2; dsif.ds_rt_value = t.rt;
    dsif.ds_md_op = t.md; dsif.ds_hilo_op = t.hl;
    dsif.ds_mem_op = t.mem; dsif.ds_mem_size = t.size;
    dsif.ds_gr_we = t.we; dsif.ds_dest = t.dest; dsif.ds_pc = t.pc;
    ms_allowin = (hold == 0);
    @(negedge clk);
    dsif.ds_to_es_valid = 1'b0;
    cyc = 0;
    while (!es_to_ms_valid && cyc < 100) begin
      chk("busy_allowin", es_allowin_w(), 0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(ecyc));
    for (int k = 0; k < hold; k++) begin
      chk("hold_allowin", es_allowin_w(), 0);
      chk("hold_valid", es_to_ms_valid, 1);
      @(negedge clk);
    end
    ms_allowin = 1'b1;
    #1;
    res = es_to_ms_result;
    wen = data_sram_wen;
    chk("result", es_to_ms_result, er);
    chk("pc", es_to_ms_pc, t.pc);
    chk("dest", es_to_ms_dest, t.dest);
    chk("load", es_load_op, t.mem == MEM_LD);
    chk("fwd_valid", es_fwd_valid, fv);
    if (fv) chk("fwd_data", es_fwd_data, er);
    chk("wreg", es_wreg_addr, t.we ? t.dest : 5'd0);
    chk("addr", data_sram_addr, ea);
    chk("addr_lo", es_to_ms_addr_lo, ea[1:0]);
    chk("wen", data_sram_wen, ew);
    if (ew != 0)
      chk("wdata", data_sram_wdata,
          (t.size == 0) ? {4{t.rt[7:0]}} :
          (t.size == 1) ? {2{t.rt[15:0]}} : t.rt);
    @(negedge clk);
    chk("one_handshake", es_to_ms_valid, 0);
    model_commit(t);
  endtask

  function automatic logic es_allowin_w();
    return dsif.es_allowin;
  endfunction

  task automatic rd(input logic [3:0] hl, input logic [31:0] exp,
                    input string tag);
    logic [31:0] r;
    logic [3:0] w;
    run(mk(12'h0, 0, 0, 0, 4'h0, hl, 3'b0, 2'd0, 1'b1), 0, r, w);
    chk(tag, r, exp);
  endtask

  function automatic ins_t rnd();
    int k = $urandom_range(0, 9);
    logic [31:0] a = $urandom, b = $urandom;
    logic [1:0] sz = 2'($urandom_range(0, 2));
    case (k)
      0, 1, 2:
        return mk(12'(1 << $urandom_range(0, 11)), a, b, 0,
                  4'h0, 4'h0, 3'b0, 2'd0, 1'($urandom));
      3: return mk(12'h0, a, b, 0, $urandom_range(0, 1) ? MD_MUL : MD_MULU,
                   4'h0, 3'b0, 2'd0, 1'b0);
      4: begin
        if ($urandom_range(0, 5) == 0) b = 0;
        if ($urandom_range(0, 5) == 0) b = b >> 20;
        return mk(12'h0, a, b, 0, $urandom_range(0, 1) ? MD_DIV : MD_DIVU,
                  4'h0, 3'b0, 2'd0, 1'b0);
      end
      5: return mk(12'h0, 0, 0, 0, 4'h0,
                   $urandom_range(0, 1) ? HL_MFHI : HL_MFLO,
                   3'b0, 2'd0, 1'b1);
      6: return mk(12'h0, a, 0, 0, 4'h0,
                   $urandom_range(0, 1) ? HL_MTHI : HL_MTLO,
                   3'b0, 2'd0, 1'b0);
      7: return mk(OP_ADD, a, b & 32'hff, 0, 4'h0, 4'h0,
                   MEM_LD, sz, 1'b1);
      default: return mk(OP_ADD, a, b & 32'hff, $urandom, 4'h0, 4'h0,
                         MEM_ST, sz, 1'b0);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0] w;
    ins_t t;
    dsif.ds_to_es_valid = 1'b0;
    dsif.ds_alu_op = '0; dsif.ds_src1 = '0; dsif.ds_src2 = '0;
    dsif.ds_rt_value = '0; dsif.ds_md_op = '0; dsif.ds_hilo_op = '0;
    dsif.ds_mem_op = '0; dsif.ds_mem_size = '0; dsif.ds_gr_we = '0;
    dsif.ds_dest = '0; dsif.ds_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_allowin", dsif.es_allowin, 1);
    chk("rst_valid", es_to_ms_valid, 0);
    chk("rst_en", data_sram_en, 1);
    chk("rst_wen", data_sram_wen, 0);
    chk("rst_result", es_to_ms_result, 0);
    chk("rst_fwd", es_fwd_valid, 0);
    chk("rst_wreg", es_wreg_addr, 0);
    chk("rst_addr", data_sram_addr, 0);
    rd(HL_MFHI, 0, "rst_hi");
    rd(HL_MFLO, 0, "rst_lo");

    run(mk(12'h0, 100, 7, 0, MD_DIVU, 4'h0, 3'b0, 2'd0, 1'b0), 0, r, w);
    rd(HL_MFLO, 14, "divu_lo");
    rd(HL_MFHI, 2, "divu_hi");
    run(mk(12'h0, -7, 2, 0, MD_DIV, 4'h0, 3'b0, 2'd0, 1'b0), 0, r, w);
    rd(HL_MFLO, 32'hffff_fffd, "div_lo");
    rd(HL_MFHI, 32'hffff_ffff, "div_hi");
    run(mk(12'h0, 7, 0, 0, MD_DIV, 4'h0, 3'b0, 2'd0, 1'b0), 0, r, w);
    rd(HL_MFLO, 32'hffff_ffff, "div0_lo");
    rd(HL_MFHI, 7, "div0_hi");
    run(mk(12'h0, 32'h8000_0000, -1, 0, MD_DIV, 4'h0, 3'b0, 2'd0, 1'b0),
        0, r, w);
    rd(HL_MFLO, 32'h8000_0000, "divovf_lo");

    run(mk(12'h0, -1, 2, 0, MD_MUL, 4'h0, 3'b0, 2'd0, 1'b0), 0, r, w);
    rd(HL_MFHI, 32'hffff_ffff, "mult_hi");
    rd(HL_MFLO, 32'hffff_fffe, "mult_lo");
    run(mk(12'h0, -1, 2, 0, MD_MULU, 4'h0, 3'b0, 2'd0, 1'b0), 0, r, w);
    rd(HL_MFHI, 1, "multu_hi");
    rd(HL_MFLO, 32'hffff_fffe, "multu_lo");
    run(mk(12'h0, 32'h1234, 0, 0, 4'h0, HL_MTHI, 3'b0, 2'd0, 1'b0), 0, r, w);
    rd(HL_MFHI, 32'h1234, "mthi");

    run(mk(OP_ADD, 32'h1000_0003, 0, 32'hAB, 4'h0, 4'h0, MEM_ST, 2'd0,
           1'b0), 0, r, w);
    chk("sb_wen", w, 4'b1000);
    run(mk(OP_ADD, 32'h1000_0002, 0, 32'hBEEF, 4'h0, 4'h0, MEM_ST, 2'd1,
           1'b0), 0, r, w);
    chk("sh_wen", w, 4'b1100);
    run(mk(OP_ADD, 32'h1000_0001, 0, 32'hBEEF, 4'h0, 4'h0, MEM_ST, 2'd1,
           1'b0), 0, r, w);
    chk("sh_mis_wen", w, 4'b0000);
    run(mk(OP_ADD, 32'h1000_0000, 0, 32'h1357, 4'h0, 4'h0, MEM_ST, 2'd2,
           1'b0), 0, r, w);
    chk("sw_wen", w, 4'b1111);

    run(mk(12'h0, 50, 6, 0, MD_DIVU, 4'h0, 3'b0, 2'd0, 1'b0), 5, r, w);
    rd(HL_MFLO, 8, "hold_lo");
    rd(HL_MFHI, 2, "hold_hi");

    t = mk(12'h0, 32'hdead_beef, 3, 0, MD_DIVU, 4'h0, 3'b0, 2'd0, 1'b0);
    @(negedge clk);
    dsif.ds_to_es_valid = 1'b1;
    dsif.ds_alu_op = t.alu; dsif.ds_src1 = t.s1; dsif.ds_src2 = t.s2;
    dsif.ds_md_op = t.md; dsif.ds_hilo_op = t.hl; dsif.ds_mem_op = t.mem;
    dsif.ds_gr_we = t.we; dsif.ds_dest = t.dest; dsif.ds_pc = t.pc;
    @(negedge clk);
    dsif.ds_to_es_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mhi = 0;
    mlo = 0;
    chk("mid_rst_allowin", dsif.es_allowin, 1);
    chk("mid_rst_valid", es_to_ms_valid, 0);
    chk("mid_rst_wreg", es_wreg_addr, 0);
    rd(HL_MFHI, 0, "mid_rst_hi");
    rd(HL_MFLO, 0, "mid_rst_lo");
    run(mk(12'h0, 9, 3, 0, MD_DIVU, 4'h0, 3'b0, 2'd0, 1'b0), 0, r, w);
    rd(HL_MFLO, 3, "post_rst_lo");
    rd(HL_MFHI, 0, "post_rst_hi");

    for (int i = 0; i < 80; i++) begin
      t = rnd();
      run(t, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0, r, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
